mem_ctrl16: RTL and testbench
=============================

Name: mem_ctrl16

Overview:
- Request/response front end that sits directly upstream of the 16-bit synchronous block RAM and drives its address, write-data and write-enable inputs.
- Converts the core's valid/ready load/store requests into BRAM cycles.
- Absorbs the BRAM's one-cycle read latency.
- Implements byte-enabled stores as read-modify-write, and flags out-of-range addresses without touching memory.
- One transaction outstanding at a time; responses are returned in order.

Parameters:
- adr_width, 11: BRAM address parameter; word depth = 1 << (adr_width-1) = 1024 by default.

Ports:
- sys_clk    input   1   system clock, all state on rising edge
- sys_rst    input   1   asynchronous, active-low reset (0 = reset)
- req_valid  input   1   request present
- req_ready  output  1   controller can accept; 1 iff state == IDLE
- req_we     input   1   1 = store, 0 = load
- req_be     input   2   byte enables; [0] -> bits 7:0, [1] -> bits 15:8; ignored for loads
- req_addr   input   16  word address
- req_wdata  input   16  store data
- rsp_valid  output  1   response present
- rsp_ready  input   1   consumer accepts response
- rsp_rdata  output  16  load data; holds last value on stores/errors
- rsp_err    output  1   address out of range
- mem_a      output  16  BRAM address (registered)
- mem_do     output  16  BRAM write data (registered)
- mem_we     output  1   BRAM write enable (registered)
- mem_di     input   16  BRAM read data, valid one cycle after mem_a is sampled

Behaviour:
- Reset (sys_rst=0, asynchronous):
  - state=IDLE; mem_we=0, mem_a=0, mem_do=0; rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Any in-flight transaction is dropped with no response and no further write.
  - req_ready=1 as soon as reset is released.
- States: IDLE, ISSUE, CAPTURE, MERGE, RESP.
- Accept occurs at the edge where req_valid & req_ready. addr, we, be and wdata are latched there and ignored afterwards.
- Range check at accept: addr >= word_depth -> go straight to RESP with rsp_err=1, mem_we stays 0, no BRAM access.
- Load: IDLE -> ISSUE (mem_a=addr, mem_we=0) -> CAPTURE -> RESP (rsp_rdata=mem_di, rsp_err=0). rsp_valid rises 3 cycles after the accept edge.
- Full store (be=11): IDLE -> ISSUE (mem_a=addr, mem_do=wdata, mem_we=1 for exactly one cycle) -> RESP (mem_we=0).
- Partial store (be=01 or 10):
  - IDLE -> ISSUE (read, mem_we=0) -> CAPTURE -> MERGE.
  - In MERGE: mem_do = enabled bytes from wdata, other bytes from mem_di; mem_we=1 for one cycle. Then -> RESP.
- Store with be=00: IDLE -> RESP, no BRAM write, rsp_err=0.
- RESP: rsp_valid=1, held stable with all response fields until rsp_ready. The handshake edge returns to IDLE and clears rsp_valid. No bypass: a new request can be accepted at the earliest one cycle after the response handshake.
- mem_we is never 1 outside ISSUE (full store) or MERGE. It is always 0 in IDLE and RESP.
- mem_a holds its value between transactions. mem_a upper bits beyond adr_width-2 are passed through unchanged; the range check guarantees they are 0 for real accesses.
- req_valid while busy: ignored, because req_ready=0. Requester must hold its signals stable.

Decomposition:
- Shared header mem16_defs.vh holds:
  - state encodings (3-bit localparams IDLE=0, ISSUE=1, CAPTURE=2, MERGE=3, RESP=4);
  - BE_FULL=2'b11, BE_NONE=2'b00;
  - word-depth derivation from adr_width.
- One natural sub-module: be_merge16, a combinational byte merge with inputs old[15:0], new[15:0], be[1:0] and output merged[15:0].
- FSM and registers stay in mem_ctrl16.

Test Plan:
- Preload BRAM word 0x005 = 0xA1B2; load addr 0x0005 -> rsp_valid 3 cycles after accept, rsp_rdata=0xA1B2, rsp_err=0, mem_we never 1.
- Store 0x1234 be=11 to 0x0010, then load 0x0010 -> mem_we high exactly 1 cycle; load returns 0x1234.
- Preload 0x0020 = 0xAABB; store 0x1122 be=01, then load -> 0xAA22. Repeat with be=10 on 0xAABB -> 0x11BB. mem_we pulses only in MERGE.
- Load addr 0x0400 (= depth 1024) -> rsp_err=1, no BRAM write, rsp_rdata unchanged; store be=00 -> memory contents unchanged, rsp_err=0.
- Hold rsp_ready=0 for 5 cycles during a load response -> rsp_valid/rsp_rdata stable, req_ready=0 throughout; after the handshake, a back-to-back request is accepted the next cycle.
- Assert sys_rst=0 mid partial store (in CAPTURE) -> mem_we=0 and rsp_valid=0 immediately, target word unchanged; after release, req_ready=1.

Source files
------------

// File: rtl/mem_ctrl16_pkg.sv
// Shared definitions for the 16-bit BRAM front end: FSM state encoding,
// byte-enable patterns and the word-depth derivation from the address width.
package mem_ctrl16_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_MERGE   = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    localparam logic [1:0] BE_FULL = 2'b11;
    localparam logic [1:0] BE_NONE = 2'b00;

    // Number of 16-bit words behind a BRAM with the given address parameter.
    function automatic int word_depth(input int aw);
        return 1 << (aw - 1);
    endfunction

endpackage

// File: rtl/mem_ctrl16_be_merge.sv
// Combinational byte merge: each byte comes from new_i when its enable is
// set, otherwise from old_i. Used for read-modify-write partial stores.
module be_merge16 (
    input  logic [15:0] old_i,
    input  logic [15:0] new_i,
    input  logic [1:0]  be_i,
    output logic [15:0] merged_o
);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_byte
            assign merged_o[gi*8 +: 8] = be_i[gi] ? new_i[gi*8 +: 8] : old_i[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_ctrl16.sv
// Valid/ready load/store front end for a 16-bit synchronous BRAM with one
// cycle read latency. One transaction in flight; partial stores are done as
// read-modify-write; out-of-range addresses answer with an error and never
// touch the memory.
module mem_ctrl16
    import mem_ctrl16_pkg::*;
#(
    parameter int adr_width = 11
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_be,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] mem_a,
    output logic [15:0] mem_do,
    output logic        mem_we,
    input  logic [15:0] mem_di
);

    localparam logic [31:0] WORD_DEPTH = 32'(word_depth(adr_width));

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  be_q, be_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] mem_a_q, mem_a_d;
    logic [15:0] mem_do_q, mem_do_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept;
    logic        in_range;
    logic [15:0] merged;

    assign accept   = req_valid && (state_q == ST_IDLE);
    assign in_range = {16'd0, req_addr} < WORD_DEPTH;

    be_merge16 u_merge (
        .old_i    (mem_di),
        .new_i    (wdata_q),
        .be_i     (be_q),
        .merged_o (merged)
    );

    // Next-state and register updates; mem_we is a one-cycle pulse by default.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        mem_a_d  = mem_a_q;
        mem_do_d = mem_do_q;
        mem_we_d = 1'b0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    be_d    = req_be;
                    wdata_d = req_wdata;
                    if (!in_range) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d = 1'b0;
                        if (req_we && (req_be == BE_NONE)) begin
                            state_d = ST_RESP;
                        end else begin
                            // Full stores write straight away; loads and
                            // partial stores start with a read of the word.
                            mem_a_d = req_addr;
                            state_d = ST_ISSUE;
                            if (req_we && (req_be == BE_FULL)) begin
                                mem_do_d = req_wdata;
                                mem_we_d = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_ISSUE: begin
                state_d = (we_q && (be_q == BE_FULL)) ? ST_RESP : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // BRAM read data is valid during this state.
                if (!we_q) begin
                    rdata_d = mem_di;
                    state_d = ST_RESP;
                end else begin
                    mem_do_d = merged;
                    mem_we_d = 1'b1;
                    state_d  = ST_MERGE;
                end
            end
            ST_MERGE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            be_q     <= BE_NONE;
            wdata_q  <= 16'd0;
            mem_a_q  <= 16'd0;
            mem_do_q <= 16'd0;
            mem_we_q <= 1'b0;
            rdata_q  <= 16'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            mem_a_q  <= mem_a_d;
            mem_do_q <= mem_do_d;
            mem_we_q <= mem_we_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_a     = mem_a_q;
    assign mem_do    = mem_do_q;
    assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_mem_ctrl16.sv
// Self-checking bench for mem_ctrl16: directed vector table, a reset-during-
// RMW sequence and randomized traffic checked against a word-array model.
module tb_mem_ctrl16;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [1:0]  req_be;
    logic [15:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [15:0] rsp_rdata;
    logic [15:0] mem_a, mem_do;
    logic        mem_we;
    logic [15:0] mem_di;

    int total = 0;
    int bad   = 0;

    mem_ctrl16 #(.adr_width(11)) dut (
        .sys_clk   (clk),
        .sys_rst   (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_a     (mem_a),
        .mem_do    (mem_do),
        .mem_we    (mem_we),
        .mem_di    (mem_di)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural BRAM: one-cycle registered read, read-before-write.
    logic [15:0] bram [0:1023];
    logic        init_en = 1'b0;
    logic        pl_en   = 1'b0;
    logic [9:0]  pl_addr = 10'd0;
    logic [15:0] pl_data = 16'd0;

    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 1024; i++) bram[i] <= 16'(i * 40503) ^ 16'h5A5A;
        end else if (pl_en) begin
            bram[pl_addr] <= pl_data;
        end else if (mem_we) begin
            bram[mem_a[9:0]] <= mem_do;
        end
        mem_di <= bram[mem_a[9:0]];
    end

    // Reference model state: word image and last load data.
    logic [15:0] ref_mem [0:1023];
    logic [15:0] ref_last;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [15:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // Model of one transaction: expected response, accept-to-RESP edge count
    // and number of write cycles, from the rules of each request kind.
    task automatic model(input logic we, input logic [1:0] be, input logic [15:0] addr,
                         input logic [15:0] wdata, output logic [15:0] rd, output logic err,
                         output int lat, output int wes);
        if (addr >= 16'd1024) begin
            err = 1'b1; rd = ref_last; lat = 1; wes = 0;
        end else if (!we) begin
            err = 1'b0; rd = ref_mem[addr[9:0]]; ref_last = rd; lat = 3; wes = 0;
        end else begin
            err = 1'b0; rd = ref_last;
            for (int b = 0; b < 2; b++)
                if (be[b]) ref_mem[addr[9:0]][b*8 +: 8] = wdata[b*8 +: 8];
            lat = (be == 2'b00) ? 1 : (be == 2'b11) ? 2 : 4;
            wes = (be == 2'b00) ? 0 : 1;
        end
    endtask

    task automatic run_txn(input logic we, input logic [1:0] be, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] exp_rd,
                           input logic exp_err, input int exp_lat, input int exp_wes, input int hold);
        int lat;
        int wes;
        check("req_ready_before", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        // Scramble request fields: the controller must use the latched copy.
        req_valid = 1'b0; req_we = ~we; req_be = ~be;
        req_addr = 16'($urandom); req_wdata = 16'($urandom);
        lat = 1; wes = 0;
        while (!rsp_valid && lat < 16) begin
            if (mem_we) wes++;
            if (req_ready) check("req_ready_busy", req_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        check("rsp_valid_seen", rsp_valid, 1);
        check("latency", lat, exp_lat);
        check("we_cycles", wes, exp_wes);
        check("rsp_err", rsp_err, exp_err);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("mem_we_resp", mem_we, 0);
        if (!exp_err && !(we && be == 2'b00)) check("mem_a", mem_a, addr);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, exp_rd);
            check("hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_cleared", rsp_valid, 0);
        check("req_ready_after", req_ready, 1);
        $display("txn we=%0b be=%b addr=%h wdata=%h rdata=%h err=%0b lat=%0d hold=%0d",
                 we, be, addr, wdata, rsp_rdata, rsp_err, lat, hold);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  be;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic        exp_err;
        int          hold;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [15:0] m_rd;
        logic        m_err;
        int          m_lat, m_wes;
        int          mism;
        logic        r_we;
        logic [1:0]  r_be;
        logic [15:0] r_addr, r_wdata;

        vecs[0]  = '{1'b0, 2'b00, 16'h0005, 16'h0000, 16'hA1B2, 1'b0, 5};
        vecs[1]  = '{1'b1, 2'b11, 16'h0010, 16'h1234, 16'hA1B2, 1'b0, 0};
        vecs[2]  = '{1'b0, 2'b00, 16'h0010, 16'h0000, 16'h1234, 1'b0, 0};
        vecs[3]  = '{1'b1, 2'b01, 16'h0020, 16'h1122, 16'h1234, 1'b0, 0};
        vecs[4]  = '{1'b0, 2'b00, 16'h0020, 16'h0000, 16'hAA22, 1'b0, 0};
        vecs[5]  = '{1'b1, 2'b10, 16'h0021, 16'h1122, 16'hAA22, 1'b0, 1};
        vecs[6]  = '{1'b0, 2'b00, 16'h0021, 16'h0000, 16'h11BB, 1'b0, 0};
        vecs[7]  = '{1'b0, 2'b00, 16'h0400, 16'h0000, 16'h11BB, 1'b1, 0};
        vecs[8]  = '{1'b1, 2'b00, 16'h0020, 16'hFFFF, 16'h11BB, 1'b0, 0};
        vecs[9]  = '{1'b0, 2'b00, 16'h0020, 16'h0000, 16'hAA22, 1'b0, 0};
        vecs[10] = '{1'b1, 2'b11, 16'hFFFF, 16'hDEAD, 16'hAA22, 1'b1, 0};
        vecs[11] = '{1'b1, 2'b11, 16'h03FF, 16'hBEEF, 16'hAA22, 1'b0, 0};
        vecs[12] = '{1'b0, 2'b00, 16'h03FF, 16'h0000, 16'hBEEF, 1'b0, 2};

        req_valid = 1'b0; req_we = 1'b0; req_be = 2'b00;
        req_addr = 16'd0; req_wdata = 16'd0; rsp_ready = 1'b0;
        ref_last = 16'd0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 16'(i * 40503) ^ 16'h5A5A;

        // Asynchronous reset: outputs must clear before any clock edge.
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_mem_we", mem_we, 0);
        check("reset_mem_a", mem_a, 0);
        check("reset_mem_do", mem_do, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        check("reset_rsp_err", rsp_err, 0);

        init_en = 1'b1;
        @(posedge clk); #1;
        init_en = 1'b0;
        preload(10'h005, 16'hA1B2);
        preload(10'h020, 16'hAABB);
        preload(10'h021, 16'hAABB);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("req_ready_post_reset", req_ready, 1);

        // Directed vector table.
        for (int v = 0; v < 13; v++) begin
            model(vecs[v].we, vecs[v].be, vecs[v].addr, vecs[v].wdata, m_rd, m_err, m_lat, m_wes);
            run_txn(vecs[v].we, vecs[v].be, vecs[v].addr, vecs[v].wdata,
                    vecs[v].exp_rd, vecs[v].exp_err, m_lat, m_wes, vecs[v].hold);
        end

        // Reset in the middle of a partial store (while in CAPTURE).
        preload(10'h030, 16'h5566);
        req_valid = 1'b1; req_we = 1'b1; req_be = 2'b01; req_addr = 16'h0030; req_wdata = 16'h0099;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_we", mem_we, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ref_last = 16'd0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("midrst_no_write", mem_we, 0);
        end
        check("midrst_req_ready", req_ready, 1);
        check("midrst_rdata", rsp_rdata, 0);
        check("midrst_word", bram[10'h030], 16'h5566);
        model(1'b0, 2'b00, 16'h0030, 16'h0000, m_rd, m_err, m_lat, m_wes);
        run_txn(1'b0, 2'b00, 16'h0030, 16'h0000, 16'h5566, 1'b0, m_lat, m_wes, 0);

        // Randomized traffic against the model.
        for (int t = 0; t < 80; t++) begin
            r_we    = 1'($urandom);
            r_be    = 2'($urandom);
            r_addr  = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(1024, 65535))
                                                  : 16'($urandom_range(0, 63));
            r_wdata = 16'($urandom);
            model(r_we, r_be, r_addr, r_wdata, m_rd, m_err, m_lat, m_wes);
            run_txn(r_we, r_be, r_addr, r_wdata, m_rd, m_err, m_lat, m_wes, $urandom_range(0, 2));
        end

        // Whole memory image must match the model.
        mism = 0;
        for (int i = 0; i < 1024; i++) if (bram[i] !== ref_mem[i]) mism++;
        check("mem_image", mism, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
